// File: rtl/sc_dmem_responder_pkg.sv
// ---------------------------------------------------------------------------
// sc_dmem_responder_pkg
// Shared constants for the single-cycle CPU data-memory responder:
//   - MMIO select bit in the CPU byte address
//   - MMIO register word offsets (addr[4:2])
//   - STATUS register bit positions
// ---------------------------------------------------------------------------
package sc_dmem_responder_pkg;

  // addr[31] set selects the MMIO window, clear selects RAM
  localparam int MMIO_SEL_BIT = 31;

  // MMIO register word offsets; byte offsets are these values times 4
  localparam logic [2:0] OFF_CYCLE     = 3'd0;  // 0x00
  localparam logic [2:0] OFF_TIMER_CMP = 3'd1;  // 0x04
  localparam logic [2:0] OFF_STATUS    = 3'd2;  // 0x08
  localparam logic [2:0] OFF_TXDATA    = 3'd3;  // 0x0C
  localparam logic [2:0] OFF_LED       = 3'd4;  // 0x10

  // STATUS register layout
  localparam int ST_TIMER_HIT  = 0;
  localparam int ST_FIFO_FULL  = 1;
  localparam int ST_FIFO_EMPTY = 2;
  localparam int ST_OVERFLOW   = 3;
  localparam int ST_COUNT_LSB  = 8;
  localparam int ST_COUNT_W    = 4;

endpackage

// File: rtl/sc_tx_fifo.sv
// ---------------------------------------------------------------------------
// sc_tx_fifo
// Circular byte FIFO feeding the TX valid/ready consumer.
// Ports:
//   clock, reset   single clock, synchronous active-high reset (empties FIFO)
//   push/push_data enqueue request and byte
//   pop            dequeue request (ignored when empty)
//   full, empty    occupancy flags
//   count          number of stored bytes, width log2(DEPTH)+1
//   head           oldest stored byte (combinational; stable while not popped)
// A push while full is accepted only if a pop happens in the same cycle; the
// new byte then lands in the slot being vacated.
// ---------------------------------------------------------------------------
module sc_tx_fifo #(
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [7:0]    head
);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          push_ok;
  logic          pop_ok;

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;
  assign head  = mem[rd_ptr_reg];

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Pointers are exactly log2(DEPTH) bits, so wrap is the natural overflow
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
    if (pop_ok)  rd_ptr_next = rd_ptr_reg + 1'b1;
    count_next = count_reg + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is not reset; only the pointers define what is valid
  always_ff @(posedge clock) begin
    if (push_ok && !reset) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/sc_dmem_responder.sv
// ---------------------------------------------------------------------------
// sc_dmem_responder
// Target end of the single-cycle CPU data port: word RAM plus an MMIO window
// holding a cycle counter, compare timer, STATUS, TX FIFO push and LEDs.
// Ports:
//   clock, reset  single clock, synchronous active-high reset
//   addr          CPU byte address (aluout); addr[31] selects MMIO
//   wdata, we     CPU store data and write strobe (data2mem, wmem)
//   rdata         combinational read data (memout)
//   irq           timer_hit flag
//   led           LED register
//   tx_valid/tx_data/tx_ready  TX FIFO head handshake to the consumer
// Optional: define DMEM_DEBUG_PORT_EN to add dbg_addr/dbg_rdata, a second
// combinational RAM read port by word index.
// ---------------------------------------------------------------------------
module sc_dmem_responder
  import sc_dmem_responder_pkg::*;
#(
  parameter int RAM_AW     = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int LED_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             we,
  output logic [31:0]      rdata,
  output logic             irq,
  output logic [LED_W-1:0] led,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready
`ifdef DMEM_DEBUG_PORT_EN
  ,
  input  logic [RAM_AW-1:0] dbg_addr,
  output logic [31:0]       dbg_rdata
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // ---------------- decode ----------------
  logic              mmio_sel;
  logic [RAM_AW-1:0] ram_idx;
  logic [2:0]        mmio_off;
  logic              wr_en;
  logic              ram_we;
  logic              cmp_we;
  logic              status_we;
  logic              led_we;
  logic              fifo_push;
  logic              fifo_pop;

  assign mmio_sel = addr[MMIO_SEL_BIT];
  assign ram_idx  = addr[RAM_AW+1:2];
  assign mmio_off = addr[4:2];

  // CPU writes are dropped while reset is held
  assign wr_en     = we && !reset;
  assign ram_we    = wr_en && !mmio_sel;
  assign cmp_we    = wr_en && mmio_sel && (mmio_off == OFF_TIMER_CMP);
  assign status_we = wr_en && mmio_sel && (mmio_off == OFF_STATUS);
  assign fifo_push = wr_en && mmio_sel && (mmio_off == OFF_TXDATA);
  assign led_we    = wr_en && mmio_sel && (mmio_off == OFF_LED);

  // ---------------- RAM ----------------
  logic [31:0] ram_mem [2**RAM_AW];

  always_ff @(posedge clock) begin
    if (ram_we) ram_mem[ram_idx] <= wdata;
  end

`ifdef DMEM_DEBUG_PORT_EN
  assign dbg_rdata = ram_mem[dbg_addr];
`endif

  // ---------------- TX FIFO ----------------
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  assign tx_valid = !fifo_empty;
  assign fifo_pop = tx_valid && tx_ready;

  sc_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_tx_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(wdata[7:0]),
    .pop      (fifo_pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .head     (tx_data)
  );

  // ---------------- registers ----------------
  logic [31:0]      cycle_reg, cycle_next;
  logic [31:0]      timer_cmp_reg, timer_cmp_next;
  logic             timer_hit_reg, timer_hit_next;
  logic             overflow_reg, overflow_next;
  logic [LED_W-1:0] led_reg, led_next;

  always_comb begin
    cycle_next     = cycle_reg + 32'd1;
    timer_cmp_next = timer_cmp_reg;
    timer_hit_next = timer_hit_reg;
    overflow_next  = overflow_reg;
    led_next       = led_reg;

    if (cmp_we) timer_cmp_next = wdata;
    if (led_we) led_next = wdata[LED_W-1:0];

    // Set takes priority over a same-cycle write-1-to-clear
    if (cycle_reg == timer_cmp_reg)
      timer_hit_next = 1'b1;
    else if (status_we && wdata[ST_TIMER_HIT])
      timer_hit_next = 1'b0;

    // A push is only dropped when full and the consumer is not popping
    if (fifo_push && fifo_full && !fifo_pop)
      overflow_next = 1'b1;
    else if (status_we && wdata[ST_OVERFLOW])
      overflow_next = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_reg     <= '0;
      timer_cmp_reg <= 32'hFFFF_FFFF;
      timer_hit_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      led_reg       <= '0;
    end else begin
      cycle_reg     <= cycle_next;
      timer_cmp_reg <= timer_cmp_next;
      timer_hit_reg <= timer_hit_next;
      overflow_reg  <= overflow_next;
      led_reg       <= led_next;
    end
  end

  assign irq = timer_hit_reg;
  assign led = led_reg;

  // ---------------- read path ----------------
  logic [31:0] count_ext;
  logic [31:0] status_word;

  assign count_ext = 32'(fifo_count);

  always_comb begin
    status_word = '0;
    status_word[ST_TIMER_HIT]                  = timer_hit_reg;
    status_word[ST_FIFO_FULL]                  = fifo_full;
    status_word[ST_FIFO_EMPTY]                 = fifo_empty;
    status_word[ST_OVERFLOW]                   = overflow_reg;
    status_word[ST_COUNT_LSB +: ST_COUNT_W]    = count_ext[ST_COUNT_W-1:0];
  end

  always_comb begin
    rdata = '0;
    if (!mmio_sel) begin
      rdata = ram_mem[ram_idx];
    end else begin
      case (mmio_off)
        OFF_CYCLE:     rdata = cycle_reg;
        OFF_TIMER_CMP: rdata = timer_cmp_reg;
        OFF_STATUS:    rdata = status_word;
        OFF_LED:       rdata = 32'(led_reg);
        default:       rdata = '0;  // TXDATA and unmapped offsets
      endcase
    end
  end

  // Address bits that alias away and count bits beyond the STATUS field
  logic unused_bits;
  assign unused_bits = &{1'b0, addr[30:RAM_AW+2], addr[1:0],
                         count_ext[31:ST_COUNT_W]};

endmodule

// File: tb/tb_sc_dmem_responder.sv
module tb_sc_dmem_responder;

  localparam logic [31:0] A_CYCLE  = 32'h8000_0000;
  localparam logic [31:0] A_TCMP   = 32'h8000_0004;
  localparam logic [31:0] A_STATUS = 32'h8000_0008;
  localparam logic [31:0] A_TXDATA = 32'h8000_000C;
  localparam logic [31:0] A_LED    = 32'h8000_0010;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        irq;
  logic [15:0] led;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
`ifdef DMEM_DEBUG_PORT_EN
  logic [9:0]  dbg_addr = '0;
  logic [31:0] dbg_rdata;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  sc_dmem_responder dut (
    .clock    (clock),
    .reset    (reset),
    .addr     (addr),
    .wdata    (wdata),
    .we       (we),
    .rdata    (rdata),
    .irq      (irq),
    .led      (led),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
`ifdef DMEM_DEBUG_PORT_EN
    ,
    .dbg_addr (dbg_addr),
    .dbg_rdata(dbg_rdata)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-16s got 0x%08h", tag, got);
    end else begin
      $display("FAIL %-16s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge, leaving time 1ns past the edge for driving/sampling
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] exp);
    we   = 1'b0;
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we    = 1'b1;
    addr  = a;
    wdata = d;
    step();
    we = 1'b0;
  endtask

  logic [7:0] exp_bytes [8];

  initial begin
    reset = 1'b1; we = 1'b0; addr = '0; wdata = '0; tx_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // ---- reset state and cycle counter ----
    rd(A_CYCLE, "cycle_0", 32'd0);
    step();
    rd(A_CYCLE, "cycle_1", 32'd1);
    repeat (4) step();
    rd(A_CYCLE, "cycle_5", 32'd5);
    rd(A_STATUS, "status_rst", 32'h0000_0004);
    check("led_rst", 32'(led), 32'd0);
    check("tx_valid_rst", 32'(tx_valid), 32'd0);
    check("irq_rst", 32'(irq), 32'd0);

    // ---- timer: write at cycle 5, counter reaches 20 after 15 edges ----
    wr(A_TCMP, 32'd20);
    rd(A_TCMP, "timer_cmp_rd", 32'd20);
    repeat (14) step();
    rd(A_CYCLE, "cycle_20", 32'd20);
    check("irq_before_hit", 32'(irq), 32'd0);
    wr(A_STATUS, 32'h1);                       // W1C on the setting edge
    check("irq_set_wins", 32'(irq), 32'd1);
    rd(A_STATUS, "status_hit", 32'h0000_0005);
    step();
    check("irq_holds", 32'(irq), 32'd1);
    wr(A_STATUS, 32'h1);
    check("irq_cleared", 32'(irq), 32'd0);

    // ---- RAM write, old value in write cycle, aliasing ----
    wr(32'h0000_0040, 32'h1111_1111);
    we = 1'b1; addr = 32'h0000_0040; wdata = 32'hDEAD_BEEF;
    #1;
    check("ram_old_in_wr", rdata, 32'h1111_1111);
    step();
    rd(32'h0000_0040, "ram_rd", 32'hDEAD_BEEF);
    rd(32'h0000_1040, "ram_alias", 32'hDEAD_BEEF);
    rd(32'h0000_0043, "ram_byte_ign", 32'hDEAD_BEEF);
    rd(A_TXDATA, "txdata_rd0", 32'd0);
    rd(32'h8000_0014, "unmapped_rd0", 32'd0);
    step();

    // ---- overflow: 9 pushes with consumer stalled ----
    for (int i = 1; i <= 9; i++) begin
      we = 1'b1; addr = A_TXDATA; wdata = 32'(i);
      if (i == 1) begin
        #1;
        check("no_bypass", 32'(tx_valid), 32'd0);
      end
      step();
    end
    we = 1'b0;
    rd(A_STATUS, "status_ovf", 32'h0000_080A);
    check("head_stalled", 32'(tx_data), 32'h01);
    step();
    check("head_holds", 32'(tx_data), 32'h01);
    tx_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      #1;
      check($sformatf("drain%0d", k), {23'd0, tx_valid, tx_data}, {23'd1, 8'(k)});
      step();
    end
    check("drained_empty", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;
    wr(A_STATUS, 32'h8);
    rd(A_STATUS, "ovf_cleared", 32'h0000_0004);

    // ---- full with simultaneous push and pop ----
    for (int i = 0; i < 8; i++) wr(A_TXDATA, 32'h11 + 32'(i));
    tx_ready = 1'b1;
    wr(A_TXDATA, 32'hAA);
    tx_ready = 1'b0;
    rd(A_STATUS, "status_full_pp", 32'h0000_0802);
    exp_bytes[0] = 8'h12; exp_bytes[1] = 8'h13; exp_bytes[2] = 8'h14;
    exp_bytes[3] = 8'h15; exp_bytes[4] = 8'h16; exp_bytes[5] = 8'h17;
    exp_bytes[6] = 8'h18; exp_bytes[7] = 8'hAA;
    tx_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check($sformatf("pp_drain%0d", k), {23'd0, tx_valid, tx_data}, {23'd1, exp_bytes[k]});
      step();
    end
    check("pp_empty", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    // ---- reset mid-stream ----
    for (int i = 0; i < 3; i++) wr(A_TXDATA, 32'hA1 + 32'(i));
    wr(A_LED, 32'h0000_1234);
    check("led_set", 32'(led), 32'h1234);
    rd(A_LED, "led_rd", 32'h0000_1234);
    rd(A_STATUS, "status_cnt3", 32'h0000_0300);
    reset = 1'b1;
    we = 1'b1; addr = A_LED; wdata = 32'h0000_FFFF;    // ignored under reset
    step();
    reset = 1'b0;
    we = 1'b0;
    check("tx_valid_mrst", 32'(tx_valid), 32'd0);
    check("led_mrst", 32'(led), 32'd0);
    rd(A_STATUS, "status_mrst", 32'h0000_0004);
    rd(32'h0000_0040, "ram_keeps", 32'hDEAD_BEEF);
    rd(A_CYCLE, "cycle_mrst", 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got %0d checks", n_checks);
    $fatal(1);
  end

endmodule
